implication_scoreboard: RTL and testbench



---
 rtl/implication_scoreboard_pkg.sv | 22 ++
 rtl/implication_scoreboard_sat_counter.sv | 35 +++
 rtl/implication_scoreboard.sv | 139 +++++++++++++
 tb/tb_implication_scoreboard.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/implication_scoreboard_pkg.sv
// Shared definitions for the implication scoreboard: delay limit, per-attempt
// result encoding and a small popcount helper.
package implication_pkg;

    localparam int unsigned MAX_DELAY_LIMIT = 15;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_PASS,
        RES_FAIL
    } result_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/implication_scoreboard_sat_counter.sv
// Saturating statistics counter: adds a multi-bit increment each cycle and
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W  = 16,
    parameter int unsigned IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  cnt
);

    localparam int unsigned SW = ((W > IW) ? W : IW) + 1;

    logic [SW-1:0] sum;

    always_comb begin
        sum = SW'(cnt) + SW'(inc);
    end

    // Any bit above the counter width means the true sum exceeds all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (|sum[SW-1:W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/implication_scoreboard.sv
// Scores every attempt of "antecedent |-> ##[MIN_DELAY:MAX_DELAY] consequent"
// as pass, fail or vacuous, with registered pulses and saturating counters.
module implication_scoreboard
    import implication_pkg::*;
#(
    parameter int unsigned MIN_DELAY = 0,
    parameter int unsigned MAX_DELAY = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             antecedent,
    input  logic             consequent,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic             fail_sticky,
    output logic [4:0]       pending,
    output logic [CNT_W-1:0] attempt_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vacuous_cnt
);

    if (MIN_DELAY > MAX_DELAY || MAX_DELAY > MAX_DELAY_LIMIT || CNT_W == 0) begin : g_bad_params
        $error("implication_scoreboard: need MIN_DELAY <= MAX_DELAY <= 15 and CNT_W > 0");
    end

    function automatic logic [15:0] range_mask(input int unsigned lo, input int unsigned hi);
        logic [15:0] m;
        for (int unsigned i = 0; i < 16; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

    function automatic logic [15:0] below_mask(input int unsigned hi);
        logic [15:0] m;
        for (int unsigned i = 0; i < 16; i++) begin
            m[i] = (i < hi);
        end
        return m;
    endfunction

    localparam logic [15:0] WINDOW = range_mask(MIN_DELAY, MAX_DELAY);
    localparam logic [15:0] KEEP   = below_mask(MAX_DELAY);

    // pend_q[k] = unresolved attempt started k cycles ago; age 0 is never stored.
    logic [15:1] pend_q;
    logic [15:0] attempts;
    logic [15:0] passed;
    logic [15:0] surv;
    logic        fail;
    result_e     res [16];

    always_comb begin
        attempts = {pend_q, antecedent};
        passed   = '0;
        surv     = '0;
        fail     = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            res[k] = RES_NONE;
            if (attempts[k] && WINDOW[k] && consequent) begin
                res[k] = RES_PASS;
            end else if (attempts[k] && k == MAX_DELAY) begin
                res[k] = RES_FAIL;
            end
            passed[k] = (res[k] == RES_PASS);
            if (res[k] == RES_FAIL) begin
                fail = 1'b1;
            end
            surv[k] = attempts[k] && (res[k] == RES_NONE) && KEEP[k];
        end
    end

    // Surviving attempts age by one; surv[15] is always 0 since MAX_DELAY <= 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            pass_pulse  <= 1'b0;
            fail_pulse  <= 1'b0;
            fail_sticky <= 1'b0;
            pending     <= '0;
        end else if (clear) begin
            pend_q      <= '0;
            pass_pulse  <= 1'b0;
            fail_pulse  <= 1'b0;
            fail_sticky <= 1'b0;
            pending     <= '0;
        end else begin
            pend_q      <= surv[14:0];
            pass_pulse  <= |passed;
            fail_pulse  <= fail;
            fail_sticky <= fail_sticky | fail;
            pending     <= popcount16(surv);
        end
    end

    logic       no_attempt;
    logic [4:0] pass_inc;

    always_comb begin
        no_attempt = !antecedent;
        pass_inc   = popcount16(passed);
    end

    sat_counter #(.W(CNT_W), .IW(1)) u_attempt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (antecedent),
        .cnt   (attempt_cnt)
    );

    sat_counter #(.W(CNT_W), .IW(5)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (pass_inc),
        .cnt   (pass_cnt)
    );

    sat_counter #(.W(CNT_W), .IW(1)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (fail),
        .cnt   (fail_cnt)
    );

    sat_counter #(.W(CNT_W), .IW(1)) u_vacuous_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (no_attempt),
        .cnt   (vacuous_cnt)
    );

endmodule

// File: tb/tb_implication_scoreboard.sv
// Bench for implication_scoreboard: four configurations driven in lockstep,
// directed scenarios plus a random run against an attempt-timestamp model.
module tb_implication_scoreboard;

    localparam int NI = 4;
    localparam int unsigned MINS [NI] = '{0, 1, 1, 2};
    localparam int unsigned MAXS [NI] = '{0, 1, 3, 3};
    localparam int unsigned CWS  [NI] = '{16, 16, 16, 4};

    logic clk = 1'b0;
    logic rst, clear, antecedent, consequent;

    logic [NI-1:0]       pp, fp, fs;
    logic [NI-1:0][4:0]  pnd;
    logic [NI-1:0][15:0] att, pas, fl, vac;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [CWS[g]-1:0] a_c, p_c, f_c, v_c;

        implication_scoreboard #(
            .MIN_DELAY (MINS[g]),
            .MAX_DELAY (MAXS[g]),
            .CNT_W     (CWS[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .antecedent  (antecedent),
            .consequent  (consequent),
            .pass_pulse  (pp[g]),
            .fail_pulse  (fp[g]),
            .fail_sticky (fs[g]),
            .pending     (pnd[g]),
            .attempt_cnt (a_c),
            .pass_cnt    (p_c),
            .fail_cnt    (f_c),
            .vacuous_cnt (v_c)
        );

        assign att[g] = 16'(a_c);
        assign pas[g] = 16'(p_c);
        assign fl[g]  = 16'(f_c);
        assign vac[g] = 16'(v_c);
    end

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: each outstanding attempt is remembered by its start cycle.
    int          cyc;
    int          st [NI][16];
    bit          sv [NI][16];
    int unsigned m_att [NI], m_pas [NI], m_fl [NI], m_vac [NI], m_pend [NI];
    bit          m_pp [NI], m_fp [NI], m_fs [NI];

    function automatic int unsigned sat(input int unsigned v, input int unsigned cmax);
        return (v > cmax) ? cmax : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_att[i] = 0; m_pas[i] = 0; m_fl[i] = 0; m_vac[i] = 0; m_pend[i] = 0;
            m_pp[i] = 0; m_fp[i] = 0; m_fs[i] = 0;
            for (int j = 0; j < 16; j++) sv[i][j] = 0;
        end
    endtask

    task automatic model_step(input bit a, input bit c, input bit clr);
        int unsigned cmax, np, nf;
        int age;
        if (clr) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                cmax = (32'd1 << CWS[i]) - 1;
                if (a) begin
                    for (int j = 0; j < 16; j++) begin
                        if (!sv[i][j]) begin
                            sv[i][j] = 1;
                            st[i][j] = cyc;
                            break;
                        end
                    end
                end
                np = 0;
                nf = 0;
                for (int j = 0; j < 16; j++) begin
                    if (sv[i][j]) begin
                        age = cyc - st[i][j];
                        if (c && age >= int'(MINS[i]) && age <= int'(MAXS[i])) begin
                            np++;
                            sv[i][j] = 0;
                        end else if (age >= int'(MAXS[i])) begin
                            nf++;
                            sv[i][j] = 0;
                        end
                    end
                end
                m_pp[i] = (np > 0);
                m_fp[i] = (nf > 0);
                m_fs[i] = m_fs[i] | (nf > 0);
                m_att[i] = sat(m_att[i] + (a ? 1 : 0), cmax);
                m_vac[i] = sat(m_vac[i] + (a ? 0 : 1), cmax);
                m_pas[i] = sat(m_pas[i] + np, cmax);
                m_fl[i]  = sat(m_fl[i] + nf, cmax);
                m_pend[i] = 0;
                for (int j = 0; j < 16; j++) m_pend[i] += sv[i][j];
            end
        end
        cyc++;
    endtask

    // Drive one cycle of inputs; on return the outputs reflect that cycle's edge.
    task automatic step(input bit a, input bit c, input bit clr);
        antecedent = a;
        consequent = c;
        clear      = clr;
        @(posedge clk);
        model_step(a, c, clr);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; antecedent = 1'b0; consequent = 1'b0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({pp[i], fp[i], fs[i], pnd[i], att[i], pas[i], fl[i], vac[i]} !== '0) begin
                fails++;
                $display("FAIL reset_state[%0d]: got pp=%b fp=%b fs=%b pend=%0d att=%0d pas=%0d fl=%0d vac=%0d, want all 0",
                         i, pp[i], fp[i], fs[i], pnd[i], att[i], pas[i], fl[i], vac[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_overlap();
        step(0, 0, 1);
        for (int c = 0; c < 8; c++) begin
            step(c == 3 || c == 5, c == 3, 0);
            tests++;
            if (pp[0] !== (c + 1 == 4)) begin
                fails++;
                $display("FAIL overlap_pass_pulse cycle %0d: got %b want %b", c + 1, pp[0], c + 1 == 4);
            end
            tests++;
            if (fp[0] !== (c + 1 == 6)) begin
                fails++;
                $display("FAIL overlap_fail_pulse cycle %0d: got %b want %b", c + 1, fp[0], c + 1 == 6);
            end
            tests++;
            if (fs[0] !== (c + 1 >= 6)) begin
                fails++;
                $display("FAIL overlap_fail_sticky cycle %0d: got %b want %b", c + 1, fs[0], c + 1 >= 6);
            end
        end
        tests++;
        if (pas[0] !== 16'd1 || fl[0] !== 16'd1 || att[0] !== 16'd2 || vac[0] !== 16'd6) begin
            fails++;
            $display("FAIL overlap_counts: got pas=%0d fl=%0d att=%0d vac=%0d want 1 1 2 6", pas[0], fl[0], att[0], vac[0]);
        end
    endtask

    task automatic test_nonoverlap();
        step(0, 0, 1);
        for (int c = 0; c < 7; c++) begin
            step(c == 2 || c == 3, c == 3 || c == 4, 0);
            tests++;
            if (pp[1] !== (c + 1 == 4 || c + 1 == 5)) begin
                fails++;
                $display("FAIL nonoverlap_pass_pulse cycle %0d: got %b want %b", c + 1, pp[1], c + 1 == 4 || c + 1 == 5);
            end
            if (c == 2) begin
                tests++;
                if (pnd[1] !== 5'd1) begin
                    fails++;
                    $display("FAIL nonoverlap_pending: got %0d want 1", pnd[1]);
                end
            end
        end
        tests++;
        if (att[1] !== 16'd2 || pas[1] !== 16'd2 || fl[1] !== 16'd0) begin
            fails++;
            $display("FAIL nonoverlap_counts: got att=%0d pas=%0d fl=%0d want 2 2 0", att[1], pas[1], fl[1]);
        end
    endtask

    task automatic test_multi_pass();
        step(0, 0, 1);
        for (int c = 0; c < 6; c++) begin
            step(c <= 2, c == 3, 0);
            tests++;
            if (pp[2] !== (c + 1 == 4)) begin
                fails++;
                $display("FAIL multi_pass_pulse cycle %0d: got %b want %b", c + 1, pp[2], c + 1 == 4);
            end
        end
        tests++;
        if (pas[2] !== 16'd3 || fl[2] !== 16'd0 || pnd[2] !== 5'd0) begin
            fails++;
            $display("FAIL multi_pass_counts: got pas=%0d fl=%0d pend=%0d want 3 0 0", pas[2], fl[2], pnd[2]);
        end
    endtask

    task automatic test_min_gap();
        step(0, 0, 1);
        for (int c = 0; c < 6; c++) begin
            step(c == 0, c == 1, 0);
            tests++;
            if (fp[3] !== (c + 1 == 4)) begin
                fails++;
                $display("FAIL min_gap_fail_pulse cycle %0d: got %b want %b", c + 1, fp[3], c + 1 == 4);
            end
        end
        tests++;
        if (fl[3] !== 16'd1 || pas[3] !== 16'd0) begin
            fails++;
            $display("FAIL min_gap_counts: got fl=%0d pas=%0d want 1 0", fl[3], pas[3]);
        end
    endtask

    task automatic test_saturate();
        step(0, 0, 1);
        for (int c = 0; c < 20; c++) begin
            step(0, 0, 0);
            tests++;
            if (vac[3] !== 16'((c + 1 > 15) ? 15 : c + 1)) begin
                fails++;
                $display("FAIL saturate_vacuous cycle %0d: got %0d want %0d", c + 1, vac[3], (c + 1 > 15) ? 15 : c + 1);
            end
        end
    endtask

    task automatic test_clear_and_reset();
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        tests++;
        if (fl[1] !== 16'd0 || fs[1] !== 1'b0 || pnd[1] !== 5'd0 || fp[1] !== 1'b0 || att[1] !== 16'd0) begin
            fails++;
            $display("FAIL clear_over_fail: got fl=%0d fs=%b pend=%0d fp=%b att=%0d want all 0", fl[1], fs[1], pnd[1], fp[1], att[1]);
        end
        step(1, 0, 0);
        tests++;
        if (pnd[1] !== 5'd1) begin
            fails++;
            $display("FAIL reset_setup_pending: got %0d want 1", pnd[1]);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({pp[i], fp[i], fs[i], pnd[i], att[i], pas[i], fl[i], vac[i]} !== '0) begin
                fails++;
                $display("FAIL async_reset[%0d]: got pp=%b fp=%b fs=%b pend=%0d att=%0d pas=%0d fl=%0d vac=%0d want all 0",
                         i, pp[i], fp[i], fs[i], pnd[i], att[i], pas[i], fl[i], vac[i]);
            end
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0);
            tests++;
            if (fp[1] !== 1'b0 || fl[1] !== 16'd0) begin
                fails++;
                $display("FAIL post_reset_no_fail cycle %0d: got fp=%b fl=%0d want 0 0", c, fp[1], fl[1]);
            end
        end
    endtask

    task automatic test_random();
        bit a, c, clr;
        for (int n = 0; n < 400; n++) begin
            a   = ($urandom_range(0, 2) != 0);
            c   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 59) == 0);
            step(a, c, clr);
            for (int i = 0; i < NI; i++) begin
                tests++;
                if (pp[i] !== m_pp[i] || fp[i] !== m_fp[i] || fs[i] !== m_fs[i]) begin
                    fails++;
                    $display("FAIL rand_flags[%0d] n=%0d: got pp=%b fp=%b fs=%b want %b %b %b",
                             i, n, pp[i], fp[i], fs[i], m_pp[i], m_fp[i], m_fs[i]);
                end
                tests++;
                if (pnd[i] !== 5'(m_pend[i])) begin
                    fails++;
                    $display("FAIL rand_pending[%0d] n=%0d: got %0d want %0d", i, n, pnd[i], m_pend[i]);
                end
                tests++;
                if (att[i] !== 16'(m_att[i]) || vac[i] !== 16'(m_vac[i])) begin
                    fails++;
                    $display("FAIL rand_att_vac[%0d] n=%0d: got %0d %0d want %0d %0d", i, n, att[i], vac[i], m_att[i], m_vac[i]);
                end
                tests++;
                if (pas[i] !== 16'(m_pas[i]) || fl[i] !== 16'(m_fl[i])) begin
                    fails++;
                    $display("FAIL rand_pass_fail[%0d] n=%0d: got %0d %0d want %0d %0d", i, n, pas[i], fl[i], m_pas[i], m_fl[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_multi_pass();
        test_min_gap();
        test_saturate();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
